// File: rtl/qsys_sysid_checker.sv
// Reads system-ID words 0 (ID) and 1 (timestamp) over Avalon-MM and checks them against expected values.
// Zero-wait check takes 3 cycles (RD_ID, RD_TS, FIN); each waitrequest cycle adds one, and a stuck slave ends the check with a timeout.
`timescale 1ns/1ps
module qsys_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1469685823,
  parameter int unsigned TIMEOUT_CYCLES     = 255,
  parameter int unsigned RECHECK_PERIOD     = 0,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [1:0] {S_IDLE, S_RD_ID, S_RD_TS, S_FIN} state_t;

  localparam int unsigned    IDLE_W    = (RECHECK_PERIOD > 1) ? $clog2(RECHECK_PERIOD) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = (RECHECK_PERIOD > 0) ? IDLE_W'(RECHECK_PERIOD - 1) : '0;
  localparam logic [15:0]    WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t              r_state;
  logic                r_first;
  logic [15:0]         r_wait_cnt;
  logic [IDLE_W-1:0]   r_idle_cnt;
  logic                r_read;
  logic                r_addr;
  logic                r_busy;
  logic                r_done;
  logic                r_id_ok;
  logic                r_ts_ok;
  logic                r_timeout;
  logic [31:0]         r_id_value;
  logic [31:0]         r_ts_value;

  logic w_recheck;
  logic w_trigger;
  logic w_expired;

  assign w_recheck = (RECHECK_PERIOD > 0) && (r_idle_cnt == IDLE_LAST);
  assign w_trigger = start || r_first || w_recheck;
  // The wait counter never passes WAIT_LAST: reaching it with waitrequest still high aborts the read.
  assign w_expired = avm_waitrequest && (r_wait_cnt == WAIT_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_first    <= AUTO_START;
      r_wait_cnt <= '0;
      r_idle_cnt <= '0;
      r_read     <= 1'b0;
      r_addr     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_id_ok    <= 1'b0;
      r_ts_ok    <= 1'b0;
      r_timeout  <= 1'b0;
      r_id_value <= '0;
      r_ts_value <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_trigger) begin
            r_state    <= S_RD_ID;
            r_first    <= 1'b0;
            r_idle_cnt <= '0;
            r_wait_cnt <= '0;
            r_read     <= 1'b1;
            r_addr     <= 1'b0;
            r_busy     <= 1'b1;
            r_timeout  <= 1'b0;
            r_id_ok    <= 1'b0;
            r_ts_ok    <= 1'b0;
          end else if (RECHECK_PERIOD > 0) begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
          end
        end
        S_RD_ID, S_RD_TS: begin
          if (!avm_waitrequest) begin
            r_wait_cnt <= '0;
            if (r_state == S_RD_ID) begin
              r_id_value <= avm_readdata;
              r_id_ok    <= (avm_readdata == EXPECTED_ID);
              r_addr     <= 1'b1;
              r_state    <= S_RD_TS;
            end else begin
              r_ts_value <= avm_readdata;
              r_ts_ok    <= (avm_readdata == EXPECTED_TIMESTAMP);
              r_read     <= 1'b0;
              r_addr     <= 1'b0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
              r_state    <= S_FIN;
            end
          end else if (w_expired) begin
            // Abort keeps any ID already captured but marks both results as failed.
            r_timeout  <= 1'b1;
            r_id_ok    <= 1'b0;
            r_ts_ok    <= 1'b0;
            r_wait_cnt <= '0;
            r_read     <= 1'b0;
            r_addr     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_state    <= S_FIN;
          end else begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign avm_address = r_addr;
  assign avm_read    = r_read;
  assign busy        = r_busy;
  assign done        = r_done;
  assign id_ok       = r_id_ok;
  assign ts_ok       = r_ts_ok;
  assign timeout     = r_timeout;
  assign id_value    = r_id_value;
  assign ts_value    = r_ts_value;

endmodule

// File: tb/tb_qsys_sysid_checker.sv
// Scoreboard bench for qsys_sysid_checker: directed checks against a programmable-wait sysid slave model.
`timescale 1ns/1ps
module tb_qsys_sysid_checker;

  localparam logic [31:0] TS = 32'd1469685823;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic        avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic        busy;
  logic        done;
  logic        id_ok;
  logic        ts_ok;
  logic        timeout;
  logic [31:0] id_value;
  logic [31:0] ts_value;

  always #5 clock = ~clock;

  qsys_sysid_checker #(
    .EXPECTED_ID(32'd0),
    .EXPECTED_TIMESTAMP(TS),
    .TIMEOUT_CYCLES(4),
    .RECHECK_PERIOD(10),
    .AUTO_START(1'b1)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .start(start),
    .avm_address(avm_address),
    .avm_read(avm_read),
    .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest),
    .busy(busy),
    .done(done),
    .id_ok(id_ok),
    .ts_ok(ts_ok),
    .timeout(timeout),
    .id_value(id_value),
    .ts_value(ts_value)
  );

  // Slave model: stalls each read for sl_w0/sl_w1 cycles, then returns sl_id/sl_ts.
  logic [31:0] sl_id;
  logic [31:0] sl_ts;
  int          sl_w0;
  int          sl_w1;
  int          sl_wcnt;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) sl_wcnt <= 0;
    else if (!avm_read || !avm_waitrequest) sl_wcnt <= 0;
    else sl_wcnt <= sl_wcnt + 1;
  end

  always_comb begin
    avm_waitrequest = avm_read && (sl_wcnt < (avm_address ? sl_w1 : sl_w0));
    avm_readdata    = avm_address ? sl_ts : sl_id;
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic        ido;
    logic        tso;
    logic        tmo;
    logic [31:0] idv;
    logic [31:0] tsv;
    int          rd0;
    int          rd1;
    int          dcyc;
  } exp_t;

  exp_t sb[$];

  task automatic push(input logic ido, input logic tso, input logic tmo,
                      input logic [31:0] idv, input logic [31:0] tsv,
                      input int rd0, input int rd1, input int dcyc);
    exp_t e;
    e.ido = ido; e.tso = tso; e.tmo = tmo; e.idv = idv; e.tsv = tsv;
    e.rd0 = rd0; e.rd1 = rd1; e.dcyc = dcyc;
    sb.push_back(e);
  endtask

  // Monitor: counts read cycles per address since the last done and scores each done.
  int   n_rd0 = 0;
  int   n_rd1 = 0;
  int   n_busy = 0;
  exp_t me;

  always @(negedge clock) begin
    if (!reset_n) begin
      n_rd0 = 0; n_rd1 = 0; n_busy = 0;
    end else begin
      if (avm_read && !avm_address) n_rd0++;
      if (avm_read && avm_address) n_rd1++;
      if (busy) n_busy++;
      if (done) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_done: done seen at cycle %0d, expected none", cyc);
        end else begin
          me = sb.pop_front();
          chk("done_cycle", cyc, me.dcyc);
          chk("id_ok", id_ok, me.ido);
          chk("ts_ok", ts_ok, me.tso);
          chk("timeout", timeout, me.tmo);
          chk("id_value", id_value, me.idv);
          chk("ts_value", ts_value, me.tsv);
          chk("id_read_cycles", n_rd0, me.rd0);
          chk("ts_read_cycles", n_rd1, me.rd1);
          chk("busy_cycles", n_busy, me.rd0 + me.rd1);
          chk("read_low_in_fin", avm_read, 1'b0);
        end
        n_rd0 = 0; n_rd1 = 0; n_busy = 0;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clock);
      if (done) seen = 1'b1;
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL done_wait: no done within %0d cycles, expected one", budget);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_avm_read", avm_read, 1'b0);
    chk("rst_avm_address", avm_address, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_id_ok", id_ok, 1'b0);
    chk("rst_ts_ok", ts_ok, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_id_value", id_value, 32'd0);
    chk("rst_ts_value", ts_value, 32'd0);
  endtask

  typedef struct {
    logic [31:0] id;
    logic [31:0] ts;
    int          w0;
    int          w1;
    logic        ido;
    logic        tso;
    logic        tmo;
    logic [31:0] idv;
    logic [31:0] tsv;
    int          rd0;
    int          rd1;
  } vec_t;

  vec_t tbl [8];

  initial begin
    //           id       ts            w0 w1    id_ok ts_ok tmo   id_value ts_value      rd0 rd1
    tbl[0] = '{32'd5, TS,            0, 0,    1'b0, 1'b1, 1'b0, 32'd5, TS,            1, 1};
    tbl[1] = '{32'd0, TS,            3, 0,    1'b1, 1'b1, 1'b0, 32'd0, TS,            4, 1};
    tbl[2] = '{32'd0, TS,            0, 1000, 1'b0, 1'b0, 1'b1, 32'd0, TS,            1, 4};
    tbl[3] = '{32'd7, TS,            0, 1000, 1'b0, 1'b0, 1'b1, 32'd7, TS,            1, 4};
    tbl[4] = '{32'd0, 32'hDEADBEEF,  0, 2,    1'b1, 1'b0, 1'b0, 32'd0, 32'hDEADBEEF,  1, 3};
    tbl[5] = '{32'd0, TS,            3, 3,    1'b1, 1'b1, 1'b0, 32'd0, TS,            4, 4};
    tbl[6] = '{32'd9, 32'd0,         4, 0,    1'b0, 1'b0, 1'b1, 32'd0, TS,            4, 0};
    tbl[7] = '{32'd0, TS,            0, 0,    1'b1, 1'b1, 1'b0, 32'd0, TS,            1, 1};

    reset_n = 1'b0;
    start   = 1'b0;
    sl_id   = 32'd0;
    sl_ts   = TS;
    sl_w0   = 0;
    sl_w1   = 0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk_reset_vals();

    // Auto check on the first clock after release.
    next_cycle();
    push(1'b1, 1'b1, 1'b0, 32'd0, TS, 1, 1, cyc + 3);
    reset_n = 1'b1;
    wait_done(100);

    for (int i = 0; i < 8; i++) begin
      next_cycle();
      @(negedge clock);
      chk("idle_read_low", avm_read, 1'b0);
      chk("idle_busy_low", busy, 1'b0);
      next_cycle();
      sl_id = tbl[i].id;
      sl_ts = tbl[i].ts;
      sl_w0 = tbl[i].w0;
      sl_w1 = tbl[i].w1;
      push(tbl[i].ido, tbl[i].tso, tbl[i].tmo, tbl[i].idv, tbl[i].tsv,
           tbl[i].rd0, tbl[i].rd1, cyc + 1 + tbl[i].rd0 + tbl[i].rd1);
      start = 1'b1;
      next_cycle();
      start = 1'b0;
      wait_done(100);
    end

    // Starts while busy and during FIN must be dropped; a start in IDLE afterwards launches.
    next_cycle();
    sl_w0 = 2;
    push(1'b1, 1'b1, 1'b0, 32'd0, TS, 3, 1, cyc + 5);
    start = 1'b1;
    next_cycle();
    start = 1'b0;
    next_cycle();
    start = 1'b1;
    next_cycle();
    start = 1'b0;
    next_cycle();
    next_cycle();
    chk("fin_done_high", done, 1'b1);
    start = 1'b1;
    next_cycle();
    start = 1'b0;
    sl_w0 = 0;
    next_cycle();
    push(1'b1, 1'b1, 1'b0, 32'd0, TS, 1, 1, cyc + 3);
    start = 1'b1;
    next_cycle();
    start = 1'b0;
    wait_done(100);

    // Periodic re-check 10 idle cycles after FIN; reset lands in its RD_TS cycle.
    push(1'b1, 1'b1, 1'b0, 32'd0, TS, 1, 1, cyc + 13);
    repeat (12) next_cycle();
    chk("periodic_rd_ts_read", avm_read, 1'b1);
    chk("periodic_rd_ts_addr", avm_address, 1'b1);
    reset_n = 1'b0;
    #1;
    chk_reset_vals();
    sb.delete();
    next_cycle();
    next_cycle();
    push(1'b1, 1'b1, 1'b0, 32'd0, TS, 1, 1, cyc + 3);
    reset_n = 1'b1;
    wait_done(100);
    push(1'b1, 1'b1, 1'b0, 32'd0, TS, 1, 1, cyc + 13);
    wait_done(100);

    next_cycle();
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/qsys_sysid_checker.md
Name: qsys_sysid_checker

Overview:
Avalon-MM read master that sequences reads of the system-ID slave: word 0 (ID) and word 1 (build timestamp). It compares both against expected values and reports match, mismatch or timeout status to the boot/health logic. It runs once after reset and again on request or periodically, and guards against a hung slave with a waitrequest timeout.

Parameters:
EXPECTED_ID, 32'd0, value required at sysid address 0
EXPECTED_TIMESTAMP, 32'd1469685823, value required at sysid address 1
TIMEOUT_CYCLES, 255, max consecutive waitrequest cycles per read before abort (1..65535)
RECHECK_PERIOD, 0, idle cycles before automatic re-check; 0 = disabled
AUTO_START, 1, 1 = launch one check on the first clock after reset release

Ports:
clock  in  1  system clock
reset_n  in  1  reset; asynchronous assert, active-low
start  in  1  one-cycle request for a check; honoured only in IDLE
avm_address  out  1  sysid word select (0 = ID, 1 = timestamp)
avm_read  out  1  read strobe
avm_readdata  in  32  read data; valid in a cycle with avm_read=1 and avm_waitrequest=0
avm_waitrequest  in  1  slave stall
busy  out  1  high in RD_ID and RD_TS
done  out  1  one-cycle pulse when a check finishes (pass, fail or timeout)
id_ok  out  1  last captured ID == EXPECTED_ID
ts_ok  out  1  last captured timestamp == EXPECTED_TIMESTAMP
timeout  out  1  last check aborted on waitrequest timeout
id_value  out  32  last captured ID
ts_value  out  32  last captured timestamp

Behaviour:
- Reset (async, reset_n=0): state=IDLE; avm_read=0; avm_address=0; busy=0; done=0; id_ok=0; ts_ok=0; timeout=0; id_value=0; ts_value=0; wait and idle counters=0; first-run flag set if AUTO_START=1. Reset mid-read drops avm_read immediately and discards the partial result.
- States: IDLE, RD_ID, RD_TS, FIN.
- IDLE -> RD_ID on any of: start=1; first-run flag set (flag then cleared); RECHECK_PERIOD>0 and idle counter reaches RECHECK_PERIOD-1. The idle counter counts only in IDLE and clears on leaving IDLE. Entering RD_ID clears timeout, id_ok and ts_ok.
- RD_ID: avm_read=1, avm_address=0, held stable while avm_waitrequest=1. On the first cycle with waitrequest=0: id_value<=avm_readdata; id_ok<=(avm_readdata==EXPECTED_ID); wait counter cleared; next state RD_TS.
- RD_TS: same handshake with avm_address=1. On acceptance: ts_value and ts_ok captured; next state FIN.
- Zero-wait slave: each read completes in 1 cycle. Start-to-done latency is 3 cycles (RD_ID, RD_TS, FIN). Each wait cycle adds one cycle.
- Timeout: the wait counter increments each cycle in RD_ID/RD_TS with waitrequest=1. When a cycle with waitrequest=1 finds the counter at TIMEOUT_CYCLES-1:
  - timeout<=1; id_ok<=0; ts_ok<=0; next state FIN.
  - avm_read drops the following cycle.
  - If the abort happens in RD_TS, id_value is retained.
- FIN: done=1 for exactly one cycle; avm_read=0; next state IDLE.
- A start received outside IDLE, including in FIN, is ignored and not queued.
- Status outputs (id_ok, ts_ok, timeout, id_value, ts_value) hold between checks.
- Wait counter is 16 bits and saturates at TIMEOUT_CYCLES-1. The idle counter is wide enough for RECHECK_PERIOD and wraps to 0 on each trigger.

Test Plan:
- Reset release, AUTO_START=1, slave zero-wait returning 0 / 1469685823 -> avm_read high 2 cycles (address 0 then 1); done pulses on cycle 3; id_ok=1, ts_ok=1, timeout=0.
- start with slave returning 32'h00000005 at address 0 -> id_ok=0, id_value=5, ts_ok=1, one done pulse.
- waitrequest held 3 cycles on the ID read -> address 0 and read held stable for 4 cycles; capture on the 4th; total latency 6 cycles; results correct.
- TIMEOUT_CYCLES=4, waitrequest stuck high in RD_TS -> abort after 4 wait cycles; timeout=1, id_ok=0, ts_ok=0, id_value kept, done pulses once, avm_read=0 afterwards.
- start pulsed while busy and again during FIN -> both ignored; exactly one done for the original check; start in the following IDLE cycle launches a new check.
- RECHECK_PERIOD=10, reset_n dropped during RD_TS of a periodic check -> outputs return to reset values immediately; after release the auto check runs, then a re-check begins 10 idle cycles after FIN.
